// File: rtl/wf_seq_engine.sv
// rtl/wf_seq_engine.sv - waveform sequencer stepping a shared DPBRAM address across NUM_CH channels
// Single-shot, continuous and N-repeat playback with first/half/done pulses and a sticky overrun flag.
module wf_seq_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [1:0]                   i_mode,
  input  logic [ADDR_WIDTH-1:0]        i_last_addr,
  input  logic [15:0]                  i_repeat,
  input  logic [NUM_CH-1:0]            i_ch_en,
  input  logic                         i_tick,
  output logic [ADDR_WIDTH-1:0]        o_ram_addr,
  output logic                         o_ram_ce,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_ram_dout,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_wf_data,
  output logic                         o_wf_valid,
  output logic [ADDR_WIDTH-1:0]        o_cur_count,
  output logic [15:0]                  o_loop_count,
  output logic                         o_int_first,
  output logic                         o_int_half,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overrun
);

  localparam int DW = NUM_CH * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_ARMED} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, last_q, last_d, cur_q, cur_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           rep_q, rep_d, loop_q, loop_d;
  logic [NUM_CH-1:0]     chen_q, chen_d;
  logic [DW-1:0]         hold_q, hold_d, data_q, data_d, ram_masked;
  logic                  valid_q, valid_d, first_q, first_d, half_q, half_d;
  logic                  done_q, done_d, ovr_q, ovr_d;

  logic [ADDR_WIDTH:0]   half_addr;
  logic [15:0]           rep_eff, loop_inc;

  // Half point is computed one bit wider so last_addr = all-ones does not wrap.
  assign half_addr = ({1'b0, last_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) >> 1;
  assign rep_eff   = (rep_q == 16'd0) ? 16'd1 : rep_q;
  assign loop_inc  = loop_q + 16'd1;

  always_comb begin
    ram_masked = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chen_q[k]) ram_masked[k*DATA_WIDTH +: DATA_WIDTH] = i_ram_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    mode_d  = mode_q;
    rep_d   = rep_q;
    chen_d  = chen_q;
    loop_d  = loop_q;
    hold_d  = hold_q;
    data_d  = data_q;
    cur_d   = cur_q;
    ovr_d   = ovr_q;
    valid_d = 1'b0;
    first_d = 1'b0;
    half_d  = 1'b0;
    done_d  = 1'b0;
    if (i_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            mode_d  = i_mode;
            last_d  = i_last_addr;
            rep_d   = i_repeat;
            chen_d  = i_ch_en;
            addr_d  = '0;
            loop_d  = '0;
            ovr_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_tick) ovr_d = 1'b1;
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (i_tick) ovr_d = 1'b1;
          hold_d  = ram_masked;
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (i_tick) begin
            data_d  = hold_q;
            cur_d   = addr_q;
            valid_d = 1'b1;
            first_d = (addr_q == '0);
            half_d  = ({1'b0, addr_q} == half_addr);
            if (addr_q != last_q) begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end else begin
              loop_d = loop_inc;
              // Modes 0 and 3 finish after one pass; mode 2 finishes when the pass count hits the target.
              if (mode_q == 2'd1 || (mode_q == 2'd2 && loop_inc != rep_eff)) begin
                addr_d  = '0;
                state_d = S_FETCH;
              end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      mode_q  <= '0;
      rep_q   <= '0;
      chen_q  <= '0;
      loop_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      cur_q   <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      rep_q   <= rep_d;
      chen_q  <= chen_d;
      loop_q  <= loop_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      first_q <= first_d;
      half_q  <= half_d;
      done_q  <= done_d;
    end
  end

  assign o_ram_addr   = addr_q;
  assign o_ram_ce     = (state_q == S_FETCH);
  assign o_wf_data    = data_q;
  assign o_wf_valid   = valid_q;
  assign o_cur_count  = cur_q;
  assign o_loop_count = loop_q;
  assign o_int_first  = first_q;
  assign o_int_half   = half_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_wf_seq_engine.sv
// tb/tb_wf_seq_engine.sv - randomized and directed bench for wf_seq_engine against a playback-level model
module tb_wf_seq_engine;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, tick;
  logic [1:0]    mode;
  logic [AW-1:0] last_addr;
  logic [15:0]   rep;
  logic [NC-1:0] ch_en;
  logic [AW-1:0] ram_addr;
  logic          ram_ce;
  logic [63:0]   ram_dout = '0;
  logic [63:0]   wf_data;
  logic          wf_valid, int_first, int_half, busy, done, overrun;
  logic [AW-1:0] cur_count;
  logic [15:0]   loop_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wf_seq_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_last_addr(last_addr), .i_repeat(rep), .i_ch_en(ch_en), .i_tick(tick),
    .o_ram_addr(ram_addr), .o_ram_ce(ram_ce), .i_ram_dout(ram_dout),
    .o_wf_data(wf_data), .o_wf_valid(wf_valid), .o_cur_count(cur_count),
    .o_loop_count(loop_count), .o_int_first(int_first), .o_int_half(int_half),
    .o_busy(busy), .o_done(done), .o_overrun(overrun)
  );

  function automatic logic [31:0] ram_word(input int a, input int ch);
    logic [31:0] av;
    av = 32'(a);
    return (ch == 0) ? av * 32'd16 : ~av;
  endfunction

  always @(posedge clk) if (ram_ce) ram_dout <= {ram_word(int'(ram_addr), 1), ram_word(int'(ram_addr), 0)};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Playback model: a run is a list of emitted addresses; a tick is accepted only 3 cycles after the previous accept/start.
  int          cyc = 0;
  bit          m_active = 0;
  int          m_ready = 0, m_addr = 0, m_last = 0, m_mode = 0, m_rep = 0;
  logic [1:0]  m_chen = 0;
  logic [15:0] m_loops = 0;
  bit          m_ovr = 0, e_valid = 0, e_first = 0, e_half = 0, e_done = 0;
  int          e_cur = 0;
  logic [63:0] e_data = 0;

  always @(posedge clk) begin
    cyc++;
    e_valid = 0; e_first = 0; e_half = 0; e_done = 0;
    if (rst) begin
      m_active = 0; m_addr = 0; m_loops = 0; m_ovr = 0; e_cur = 0; e_data = 0;
      m_last = 0; m_mode = 0; m_rep = 0; m_chen = 0;
    end else if (stop) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_mode = int'(mode); m_last = int'(last_addr); m_rep = (rep == 0) ? 1 : int'(rep);
        m_chen = ch_en; m_addr = 0; m_loops = 0; m_ovr = 0; m_active = 1; m_ready = cyc + 3;
      end
    end else if (tick) begin
      if (cyc < m_ready) m_ovr = 1;
      else begin
        e_valid = 1; e_cur = m_addr;
        e_data = {m_chen[1] ? ram_word(m_addr, 1) : 32'd0, m_chen[0] ? ram_word(m_addr, 0) : 32'd0};
        e_first = (m_addr == 0);
        e_half = (m_addr == (m_last + 1) / 2);
        if (m_addr != m_last) begin
          m_addr++; m_ready = cyc + 3;
        end else begin
          m_loops++;
          if (m_mode == 1 || (m_mode == 2 && int'(m_loops) != m_rep)) begin
            m_addr = 0; m_ready = cyc + 3;
          end else begin
            e_done = 1; m_active = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_active));
      check("valid", 64'(wf_valid), 64'(e_valid));
      check("data", wf_data, e_data);
      check("cur_count", 64'(cur_count), 64'(e_cur));
      check("loop_count", 64'(loop_count), 64'(m_loops));
      check("int_first", 64'(int_first), 64'(e_first));
      check("int_half", 64'(int_half), 64'(e_half));
      check("done", 64'(done), 64'(e_done));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("ram_ce", 64'(ram_ce), 64'(m_active && (m_ready - cyc == 3)));
      if (ram_ce) check("ram_addr", 64'(ram_addr), 64'(m_addr));
    end
  end

  int          n_valid, n_first, n_half, n_done;
  int          q_addr[$];
  logic [63:0] q_data[$];
  bit          q_first[$], q_half[$], q_done[$];

  always @(posedge clk) begin
    #3;
    if (chk_en && wf_valid) begin
      n_valid++;
      if (int_first) n_first++;
      if (int_half) n_half++;
      if (done) n_done++;
      q_addr.push_back(int'(cur_count)); q_data.push_back(wf_data);
      q_first.push_back(int_first); q_half.push_back(int_half); q_done.push_back(done);
    end
  end

  task automatic clear_mon();
    n_valid = 0; n_first = 0; n_half = 0; n_done = 0;
    q_addr.delete(); q_data.delete(); q_first.delete(); q_half.delete(); q_done.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] md, input int la, input int rp, input logic [1:0] en);
    mode = md; last_addr = AW'(la); rep = 16'(rp); ch_en = en; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_ticks(input int count, input int gap);
    cycles(2);
    repeat (count) begin
      tick = 1;
      @(negedge clk);
      tick = 0;
      cycles(gap - 1);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check("wait_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; tick = 0; mode = 0; last_addr = 0; rep = 0; ch_en = 0;
    cycles(2);
    chk_en = 1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", wf_data, 64'd0);
    rst = 0;
    cycles(1);

    clear_mon();
    do_start(2'd0, 3, 0, 2'b11);
    run_ticks(4, 5);
    wait_idle(20);
    check("ss_nvalid", 64'(n_valid), 64'd4);
    for (int i = 0; i < 4; i++) check("ss_ch0", q_data[i][31:0], 64'(i * 16));
    check("ss_ch1_a1", q_data[1][63:32], 64'h0000_0000_FFFF_FFFE);
    check("ss_first1", 64'(q_first[0]), 64'd1);
    check("ss_half3", 64'(q_half[2]), 64'd1);
    check("ss_done4", 64'(q_done[3]), 64'd1);
    check("ss_loop", 64'(loop_count), 64'd1);

    clear_mon();
    do_start(2'd2, 1, 3, 2'b11);
    run_ticks(9, 4);
    wait_idle(20);
    check("rp3_nvalid", 64'(n_valid), 64'd6);
    for (int i = 0; i < 6; i++) check("rp3_addr", 64'(q_addr[i]), 64'(i % 2));
    check("rp3_loop", 64'(loop_count), 64'd3);
    check("rp3_done", 64'(n_done), 64'd1);

    clear_mon();
    do_start(2'd2, 1, 0, 2'b11);
    run_ticks(5, 4);
    wait_idle(20);
    check("rp0_nvalid", 64'(n_valid), 64'd2);

    clear_mon();
    do_start(2'd1, 999, 0, 2'b11);
    run_ticks(2500, 3);
    check("ct_first", 64'(n_first), 64'd3);
    check("ct_half", 64'(n_half), 64'd2);
    check("ct_loop", 64'(loop_count), 64'd2);
    check("ct_nodone", 64'(n_done), 64'd0);
    check("ct_wrap", 64'(q_addr[1000]), 64'd0);
    stop = 1;
    @(negedge clk);
    stop = 0;
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_hold", wf_data, {~32'd499, 32'd499 * 32'd16});

    clear_mon();
    do_start(2'd0, 3, 0, 2'b11);
    cycles(2);
    tick = 1; @(negedge clk); tick = 1; @(negedge clk); tick = 0;
    check("ovr_set", 64'(overrun), 64'd1);
    run_ticks(3, 5);
    wait_idle(20);
    check("ovr_nvalid", 64'(n_valid), 64'd4);
    check("ovr_addr3", 64'(q_addr[3]), 64'd3);
    check("ovr_sticky", 64'(overrun), 64'd1);
    do_start(2'd0, 3, 0, 2'b11);
    check("ovr_clear", 64'(overrun), 64'd0);
    stop = 1; @(negedge clk); stop = 0;

    clear_mon();
    do_start(2'd0, 1, 0, 2'b10);
    run_ticks(2, 4);
    wait_idle(20);
    check("mask_ch0", q_data[0][31:0], 64'd0);
    check("mask_ch1", q_data[0][63:32], 64'hFFFF_FFFF);

    clear_mon();
    do_start(2'd0, 0, 0, 2'b11);
    run_ticks(3, 4);
    wait_idle(20);
    check("l0_nvalid", 64'(n_valid), 64'd1);
    check("l0_flags", {61'd0, q_first[0], q_half[0], q_done[0]}, 64'd7);

    for (int r = 0; r < 8; r++) begin
      do_start(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      for (int c = 0; c < 80; c++) begin
        tick = ($urandom_range(0, 2) == 0);
        stop = ($urandom_range(0, 79) == 0);
        start = ($urandom_range(0, 29) == 0);
        mode = 2'($urandom_range(0, 3)); last_addr = AW'($urandom_range(0, 7));
        @(negedge clk);
      end
      tick = 0; stop = 1; start = 0;
      @(negedge clk);
      stop = 0;
    end

    do_start(2'd1, 9, 0, 2'b11);
    run_ticks(4, 3);
    rst = 1; @(negedge clk); rst = 0;
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_data", wf_data, 64'd0);
    check("rr_outs", {52'd0, cur_count, wf_valid, done}, 64'd0);
    check("rr_loop", 64'(loop_count), 64'd0);
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
